// File: rtl/sweep_ctrl_if.sv
// Sweep controller bus: control requests and sweep configuration in,
// count, direction and status out.
//   master : drives start/stop/pause/tick/dir_in/mode/limit, observes status
//   slave  : the sweep controller itself
interface sweep_ctrl_if #(
  parameter int unsigned W = 6
) ();
  logic         start;
  logic         stop;
  logic         pause;
  logic         tick;
  logic         dir_in;
  logic         mode;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         dir;
  logic         busy;
  logic         done;
  logic         turn;

  modport master (
    output start, stop, pause, tick, dir_in, mode, limit,
    input  count, dir, busy, done, turn
  );

  modport slave (
    input  start, stop, pause, tick, dir_in, mode, limit,
    output count, dir, busy, done, turn
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Up/down sweep controller with one-shot and optional ping-pong operation.
// Ports:
//   clock : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : sweep_ctrl_if.slave
//             in : start, stop, pause, tick, dir_in, mode, limit
//             out: count, dir, busy, done, turn (all registered)
// Build option: define SWEEP_CTRL_PINGPONG_EN to enable ping-pong mode and
// the turn pulse; otherwise mode is ignored, every sweep is one-shot and
// turn is held at 0.
module sweep_ctrl #(
  parameter int unsigned W = 6
) (
  input logic         clock,
  input logic         rst,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] limit_q, limit_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         turn_q, turn_d;
  logic         load_c;
  logic         terminal_c;
  logic         pingpong_c;

`ifdef SWEEP_CTRL_PINGPONG_EN
  logic mode_q;

  // Sweep mode, captured only when a new sweep is accepted.
  always_ff @(posedge clock) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (load_c) begin
      mode_q <= bus.mode;
    end
  end

  assign pingpong_c = mode_q;
  assign bus.turn   = turn_q;
`else
  logic mode_unused;

  assign mode_unused = bus.mode;
  assign pingpong_c  = 1'b0;
  assign bus.turn    = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      turn_q  <= turn_d;
    end
  end

  // Next state and datapath; stop outranks start, start outranks pause,
  // pause outranks tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    turn_d  = 1'b0;
    load_c  = 1'b0;

    // Endpoint reached on this tick: top of an up sweep or zero going down.
    terminal_c = bus.tick && (dir_q ? (count_q == '0) : (count_q == limit_q));

    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (bus.start) begin
            load_c  = 1'b1;
            state_d = RUN;
            limit_d = bus.limit;
            dir_d   = bus.dir_in;
            count_d = bus.dir_in ? bus.limit : '0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (terminal_c) begin
            // Count holds at the endpoint in both modes.
            if (pingpong_c) begin
              dir_d  = ~dir_q;
              turn_d = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else if (bus.tick) begin
            count_d = dir_q ? (count_q - W'(1)) : (count_q + W'(1));
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter W, default 6, count width in bits.
REQ-002 Port clock  input  1  rising-edge clock, sole clock domain.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port start  input  1  request a new sweep, sampled when IDLE or DONE.
REQ-005 Port stop  input  1  abort current sweep, return to IDLE.
REQ-006 Port pause  input  1  level; freeze stepping while high.
REQ-007 Port tick  input  1  step enable; count moves only on cycles with tick high.
REQ-008 Port dir_in  input  1  initial direction, 0 = up from 0, 1 = down from limit.
REQ-009 Port mode  input  1  0 = one-shot, 1 = ping-pong; sampled with start.
REQ-010 Port limit  input  W  sweep endpoint; sampled with start.
REQ-011 Port count  output  W  current count value.
REQ-012 Port dir  output  1  current direction, 0 = up, 1 = down.
REQ-013 Port busy  output  1  high in RUN or PAUSE.
REQ-014 Port done  output  1  one-cycle pulse on one-shot completion.
REQ-015 Port turn  output  1  one-cycle pulse on a ping-pong direction reversal.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, encoded in registers updated only on the rising edge of clock.
REQ-017 Start in IDLE/DONE SHALL latch limit, mode and dir_in; load count = dir_in ? limit : 0; set dir = dir_in; enter RUN on the next edge.
REQ-018 Start SHALL be ignored in RUN and PAUSE.
REQ-019 In RUN with tick high and no terminal condition, count SHALL become count+1 when dir=0 and count-1 when dir=1, modulo 2^W.
REQ-020 Terminal condition: tick high and (dir=0 and count==latched limit) or (dir=1 and count==0).
REQ-021 Terminal in one-shot SHALL hold count, enter DONE, and assert done for exactly that one cycle in DONE.
REQ-022 Terminal in ping-pong SHALL hold count, invert dir, pulse turn for one cycle, and stay in RUN; the next tick steps in the new direction.
REQ-023 Latched limit 0 SHALL make the first tick terminal (no count change).
REQ-024 DONE SHALL return to IDLE after one cycle unless start is high, in which case REQ-017 applies.
REQ-025 Pause high in RUN SHALL enter PAUSE the next edge with count frozen; tick in that same cycle SHALL be ignored.
REQ-026 Pause low in PAUSE SHALL return to RUN; stepping resumes on the first subsequent tick.
REQ-027 Stop SHALL move any state to IDLE on the next edge, hold count and dir, and suppress done/turn.
REQ-028 Priority per cycle SHALL be rst > stop > start > pause > tick.
REQ-029 Changes of limit, mode or dir_in after start SHALL not affect the running sweep.

Reset
REQ-030 rst high at an edge SHALL force state IDLE, count 0, dir 0, busy 0, done 0, turn 0, latched limit 0, latched mode 0, overriding all other inputs, including mid-sweep.

Configuration
REQ-031 Macro SWEEP_CTRL_PINGPONG_EN defined: mode and turn behave per REQ-009, REQ-022; undefined: mode is ignored, every sweep is one-shot, and turn is tied to 0.

Verification
REQ-032 rst mid-sweep at count 0x17 -> next cycle count=0, dir=0, busy=0, state IDLE.
REQ-033 start, dir_in=0, mode=0, limit=5, tick continuous -> count 0,1,2,3,4,5; done pulses once on the cycle after count reaches 5; busy clears; count stays 5.
REQ-034 start, dir_in=1, mode=1, limit=3, tick continuous -> count 3,2,1,0,0(turn=1),1,2,3,3(turn=1),2...; dir toggles at each turn.
REQ-035 Running up, count=10, pause high 4 cycles with tick high -> count stays 10; after pause drops, next tick gives 11.
REQ-036 stop and tick high together at count=20 -> count stays 20, state IDLE, no done pulse; start the same cycle as stop is also ignored.
REQ-037 limit=0, dir_in=0, one-shot -> first tick gives done with count=0; with macro undefined and mode=1 -> identical one-shot result, turn never asserted.
